// File: rtl/regfile_sequencer_if.sv
// Instruction handshake and register-file bus of regfile_sequencer.
// output_Trap exists only when REGFILE_SEQUENCER_OVF_TRAP_EN is defined.
interface regfile_sequencer_if;
    logic       input_Instr_Valid;
    logic [7:0] input_Instr;
    logic       output_Instr_Ready;
    logic       output_RF_Reset;
    logic       output_RF_Read_Write;
    logic [1:0] output_RF_Read_Register1;
    logic [1:0] output_RF_Read_Register2;
    logic [1:0] output_RF_Write_Register;
    logic [7:0] output_RF_Write_Data;
    logic [7:0] input_RF_Read_Data1;
    logic [7:0] input_RF_Read_Data2;
    logic       output_Busy;
    logic       output_Done;
    logic       output_Overflow;
`ifdef REGFILE_SEQUENCER_OVF_TRAP_EN
    logic       output_Trap;
`endif

    // Instruction source together with the register file.
    modport master (
        output input_Instr_Valid, input_Instr, input_RF_Read_Data1, input_RF_Read_Data2,
        input  output_Instr_Ready, output_RF_Reset, output_RF_Read_Write,
               output_RF_Read_Register1, output_RF_Read_Register2,
               output_RF_Write_Register, output_RF_Write_Data,
               output_Busy, output_Done, output_Overflow
`ifdef REGFILE_SEQUENCER_OVF_TRAP_EN
        , input output_Trap
`endif
    );

    // The sequencer itself.
    modport slave (
        input  input_Instr_Valid, input_Instr, input_RF_Read_Data1, input_RF_Read_Data2,
        output output_Instr_Ready, output_RF_Reset, output_RF_Read_Write,
               output_RF_Read_Register1, output_RF_Read_Register2,
               output_RF_Write_Register, output_RF_Write_Data,
               output_Busy, output_Done, output_Overflow
`ifdef REGFILE_SEQUENCER_OVF_TRAP_EN
        , output output_Trap
`endif
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle control unit for a 4 x 8-bit register file: CLEAR, IDLE, READ, EXEC, WRITE.
// Define REGFILE_SEQUENCER_OVF_TRAP_EN to suppress overflowing writes and add a sticky output_Trap.
module regfile_sequencer #(
    parameter int unsigned CLEAR_CYCLES = 1
) (
    input  logic               input_Clock,
    input  logic               input_Reset,
    regfile_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LI  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;
    localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] clear_cnt_q;
    logic [7:0] instr_q;
    logic [7:0] result_q;
    logic       ovf_q;
    logic       done_q;
    logic       ovf_pulse_q;
    logic       accept;
    logic       write_en;
    logic [7:0] alu_result;
    logic       alu_ovf;
    logic [7:0] op_a, op_b;

    assign op_a = bus.input_RF_Read_Data1;
    assign op_b = bus.input_RF_Read_Data2;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (instr_q[7:6])
            OP_ADD: begin
                alu_result = op_a + op_b;
                alu_ovf    = (op_a[7] == op_b[7]) && (alu_result[7] != op_a[7]);
            end
            OP_SUB: begin
                alu_result = op_a - op_b;
                alu_ovf    = (op_a[7] != op_b[7]) && (alu_result[7] != op_a[7]);
            end
            OP_AND:  alu_result = op_a & op_b;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_CLEAR: if (clear_cnt_q == CLEAR_LAST) state_d = ST_IDLE;
            ST_IDLE: begin
                if (bus.input_Instr_Valid) begin
                    accept  = 1'b1;
                    // LI carries its operand in the instruction, so it skips the read phase.
                    state_d = (bus.input_Instr[7:6] == OP_LI) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge input_Clock or negedge input_Reset) begin
        if (!input_Reset) begin
            state_q     <= ST_CLEAR;
            clear_cnt_q <= '0;
            instr_q     <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            ovf_pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            done_q      <= (state_q == ST_WRITE);
            ovf_pulse_q <= (state_q == ST_WRITE) && ovf_q;
            if (state_q == ST_CLEAR) clear_cnt_q <= clear_cnt_q + 4'd1;
            if (accept) begin
                instr_q  <= bus.input_Instr;
                result_q <= {{4{bus.input_Instr[3]}}, bus.input_Instr[3:0]};
                ovf_q    <= 1'b0;
            end else if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                ovf_q    <= alu_ovf;
            end
        end
    end

`ifdef REGFILE_SEQUENCER_OVF_TRAP_EN
    logic trap_q;

    always_ff @(posedge input_Clock or negedge input_Reset) begin
        if (!input_Reset) begin
            trap_q <= 1'b0;
        end else if ((state_q == ST_WRITE) && ovf_q) begin
            trap_q <= 1'b1;
        end
    end

    assign write_en         = (state_q == ST_WRITE) && !ovf_q;
    assign bus.output_Trap  = trap_q;
`else
    assign write_en         = (state_q == ST_WRITE);
`endif

    assign bus.output_Instr_Ready       = (state_q == ST_IDLE);
    assign bus.output_Busy              = (state_q != ST_IDLE);
    assign bus.output_RF_Reset          = (state_q == ST_CLEAR);
    assign bus.output_RF_Read_Write     = write_en;
    assign bus.output_RF_Read_Register1 = instr_q[5:4];
    assign bus.output_RF_Read_Register2 = instr_q[3:2];
    assign bus.output_RF_Write_Register = (instr_q[7:6] == OP_LI) ? instr_q[5:4] : instr_q[1:0];
    assign bus.output_RF_Write_Data     = result_q;
    assign bus.output_Done              = done_q;
    assign bus.output_Overflow          = ovf_pulse_q;
endmodule
